// File: rtl/inst_mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction memory controller.
package inst_mem_ctrl_pkg;

    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int MEM_ADDRESS_LEN   = 32;
    localparam int INST_MEM_LATENCY  = 10;
    localparam int LINE_OFFSET_BITS  = 4;
    localparam int CNT_W             = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        FILL = 2'b10,
        ACK  = 2'b11
    } mem_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Line storage: one synchronous write port, one asynchronous read port, no reset.
module inst_mem_array
    import inst_mem_ctrl_pkg::*;
#(
    parameter int MEM_LINES = 256,
    parameter int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [IDX_W-1:0]             waddr,
    input  logic [ICACHE_LINE_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]             raddr,
    output logic [ICACHE_LINE_WIDTH-1:0] rdata
);

    logic [ICACHE_LINE_WIDTH-1:0] mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_ctrl.sv
// Fixed-latency instruction line memory: accepts one iCache request, waits
// MEM_LATENCY cycles, then presents the line (data_rdy) and a fill ack.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = INST_MEM_LATENCY,
    parameter int MEM_LINES   = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic [MEM_ADDRESS_LEN-1:0]   req_addr,
    input  logic                         load_en,
    input  logic [MEM_ADDRESS_LEN-1:0]   load_addr,
    input  logic [ICACHE_LINE_WIDTH-1:0] load_data,
    output logic [ICACHE_LINE_WIDTH-1:0] data_line,
    output logic                         data_rdy,
    output logic                         filled_ack,
    output logic                         busy
);

    localparam int              IDX_W    = $clog2(MEM_LINES);
    localparam int              IDX_HI   = IDX_W + LINE_OFFSET_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    mem_state_e                   state;
    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             line_idx;
    logic [IDX_W-1:0]             req_idx;
    logic [IDX_W-1:0]             load_idx;
    logic [ICACHE_LINE_WIDTH-1:0] rd_line;
    logic                         mem_we;

    // Address bits above the array size are don't-care, so addresses wrap.
    assign req_idx  = req_addr[IDX_HI:LINE_OFFSET_BITS];
    assign load_idx = load_addr[IDX_HI:LINE_OFFSET_BITS];
    assign mem_we   = load_en && (state == IDLE);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[MEM_ADDRESS_LEN-1:IDX_HI+1], req_addr[LINE_OFFSET_BITS-1:0],
                                load_addr[MEM_ADDRESS_LEN-1:IDX_HI+1], load_addr[LINE_OFFSET_BITS-1:0]};

    inst_mem_array #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_idx),
        .wdata (load_data),
        .raddr (line_idx),
        .rdata (rd_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            line_idx   <= '0;
            data_line  <= '0;
            data_rdy   <= 1'b0;
            filled_ack <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_rdy   <= 1'b0;
            filled_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        line_idx <= req_idx;
                        cnt      <= CNT_LOAD;
                        state    <= WAIT;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        data_line <= rd_line;
                        data_rdy  <= 1'b1;
                        state     <= FILL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FILL: begin
                    filled_ack <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    // The ACK exit edge doubles as the first IDLE edge, so a held
                    // request chains fills MEM_LATENCY+2 cycles apart.
                    if (req) begin
                        line_idx <= req_idx;
                        cnt      <= CNT_LOAD;
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench: two DUTs (latency 10 and 1) share random stimulus; a
// transaction-level model predicts each fill, a negedge monitor checks it.
module tb_inst_mem_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [31:0]  req_addr;
    logic         load_en;
    logic [31:0]  load_addr;
    logic [127:0] load_data;

    logic [127:0] line_o [2];
    logic         rdy_o  [2];
    logic         ack_o  [2];
    logic         busy_o [2];

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    exp_t         q [2][$];
    logic [127:0] mem_m [2][256];
    logic [127:0] exp_line [2];
    int           ack_due [2];
    int           req_ok [2];
    int           load_ok [2];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    inst_mem_ctrl #(.MEM_LATENCY(10), .MEM_LINES(256)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .data_line(line_o[0]), .data_rdy(rdy_o[0]), .filled_ack(ack_o[0]), .busy(busy_o[0])
    );

    inst_mem_ctrl #(.MEM_LATENCY(1), .MEM_LINES(256)) dut1 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .data_line(line_o[1]), .data_rdy(rdy_o[1]), .filled_ack(ack_o[1]), .busy(busy_o[1])
    );

    function automatic int lat(int k);
        return (k == 0) ? 10 : 1;
    endfunction

    task automatic check(string name, int k, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: a request is accepted at any edge once the previous fill
    // has had MEM_LATENCY+2 cycles; loads land only when the block is truly idle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                req_ok[k]  = cyc + 1;
                load_ok[k] = cyc + 1;
            end else begin
                if (load_en && cyc >= load_ok[k]) mem_m[k][load_addr[11:4]] = load_data;
                if (req && cyc >= req_ok[k]) begin
                    exp_t e;
                    e.cyc  = cyc + lat(k);
                    e.data = mem_m[k][req_addr[11:4]];
                    q[k].push_back(e);
                    req_ok[k]  = cyc + lat(k) + 2;
                    load_ok[k] = cyc + lat(k) + 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                check("reset_rdy", k, 128'(rdy_o[k]), 128'd0);
                check("reset_ack", k, 128'(ack_o[k]), 128'd0);
                check("reset_busy", k, 128'(busy_o[k]), 128'd0);
                check("reset_line", k, line_o[k], 128'd0);
                q[k].delete();
                exp_line[k] = '0;
                ack_due[k]  = -1;
            end else begin
                if (rdy_o[k]) begin
                    if (q[k].size() == 0) begin
                        check("spurious_rdy", k, 128'(rdy_o[k]), 128'd0);
                    end else begin
                        exp_t e;
                        e = q[k].pop_front();
                        check("rdy_cycle", k, 128'(cyc), 128'(e.cyc));
                        exp_line[k] = e.data;
                        ack_due[k]  = cyc + 1;
                    end
                end else if (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
                    check("missing_rdy", k, 128'(rdy_o[k]), 128'd1);
                    void'(q[k].pop_front());
                end
                check("data_line", k, line_o[k], exp_line[k]);
                check("filled_ack", k, 128'(ack_o[k]), 128'(cyc == ack_due[k]));
                check("busy", k, 128'(busy_o[k]), 128'(cyc + 1 < load_ok[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic pulse_req(logic [31:0] a);
        req = 1'b1;
        req_addr = a;
        step();
        req = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_ok[k] = 0; load_ok[k] = 0; ack_due[k] = -1; exp_line[k] = '0;
        end
        reset = 1'b1; req = 1'b0; req_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        idle(3);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i) << 4;
            load_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        load_en = 1'b0;

        // Line 3 = A..., read via 0x30 and via the wrapping alias 0x1030.
        load_en = 1'b1; load_addr = 32'h30; load_data = {32{4'hA}};
        step();
        load_en = 1'b0;
        pulse_req(32'h30);
        idle(14);
        pulse_req(32'h1030);
        idle(14);

        // Held request: fills chain back to back.
        req = 1'b1; req_addr = 32'h50;
        idle(30);
        req = 1'b0;
        idle(14);

        // Load issued while the slow DUT is mid-WAIT, then re-read that line.
        pulse_req(32'h70);
        idle(3);
        load_en = 1'b1; load_addr = 32'h70; load_data = {4{32'hDEADBEEF}};
        step();
        load_en = 1'b0;
        idle(14);
        pulse_req(32'h70);
        idle(14);

        // Same-cycle load and request: the read must see the new data.
        req = 1'b1; req_addr = 32'h90;
        load_en = 1'b1; load_addr = 32'h90; load_data = {4{32'h12345678}};
        step();
        req = 1'b0; load_en = 1'b0;
        idle(14);

        // Reset five cycles into a fill aborts it; next request completes.
        pulse_req(32'h30);
        idle(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(20);
        pulse_req(32'h30);
        idle(14);

        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req       = ($urandom_range(0, 3) == 0);
            req_addr  = $urandom;
            load_en   = !reset && ($urandom_range(0, 5) == 0);
            load_addr = $urandom;
            load_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        reset = 1'b0; req = 1'b0; load_en = 1'b0;
        idle(20);

        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (q[k].size() != 0) begin
                n_bad++;
                $display("FAIL drain dut%0d: %0d fills outstanding, expected 0", k, q[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
